// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the register hazard scoreboard.
// Holds the per-register entry layout and the stall output bundle.
package hazard_scoreboard_pkg;

    localparam int HAZ_LAT_W = 3;

    // Pending state of one architectural register.
    typedef struct packed {
        logic                 pend_wb;
        logic [HAZ_LAT_W-1:0] cnt;
    } sb_entry_t;

    // Stall and hazard controls presented to the front end.
    typedef struct packed {
        logic PCWrite_n;
        logic if_id_Write_n;
        logic is_data_stall;
        logic is_control_hazard;
    } hazard_out_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Bundle between the pipeline (master) and the scoreboard (slave).
// Carries issue/writeback events, ID sources, redirect and stall results.
interface hazard_scoreboard_if #(
    parameter int NUM_REGS   = 32,
    parameter int REG_ADDR_W = 5,
    parameter int LAT_W      = 3,
    parameter int CNT_W      = 32
);
    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] issue_rd;
    logic [LAT_W-1:0]      issue_lat;
    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [REG_ADDR_W-1:0] if_id_rs1;
    logic [REG_ADDR_W-1:0] if_id_rs2;
    logic                  if_id_rs1_used;
    logic                  if_id_rs2_used;
    logic                  beu_redirect;
    logic                  PCWrite_n;
    logic                  if_id_Write_n;
    logic                  is_data_stall;
    logic                  is_control_hazard;
    logic [NUM_REGS-1:0]   busy_vec;
    logic [CNT_W-1:0]      stall_count;

    modport master (
        output issue_valid, issue_rd, issue_lat,
        output wb_valid, wb_rd,
        output if_id_rs1, if_id_rs2,
        output if_id_rs1_used, if_id_rs2_used,
        output beu_redirect,
        input  PCWrite_n, if_id_Write_n,
        input  is_data_stall, is_control_hazard,
        input  busy_vec, stall_count
    );

    modport slave (
        input  issue_valid, issue_rd, issue_lat,
        input  wb_valid, wb_rd,
        input  if_id_rs1, if_id_rs2,
        input  if_id_rs1_used, if_id_rs2_used,
        input  beu_redirect,
        output PCWrite_n, if_id_Write_n,
        output is_data_stall, is_control_hazard,
        output busy_vec, stall_count
    );
endinterface

// File: rtl/hazard_sb_entry.sv
// One scoreboard entry: pend_wb flag plus latency down-counter.
// Ports: issue_i/lat_i load, wb_hit_i clear, busy_o, ready_now_o.
module hazard_sb_entry #(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_i,
    input  logic [LAT_W-1:0] lat_i,
    input  logic             wb_hit_i,
    output logic             busy_o,
    output logic             ready_now_o
);
    logic             pend_q, pend_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        pend_d = pend_q & ~wb_hit_i;
        cnt_d  = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
        // A new producer replaces whatever was pending (WAW).
        if (issue_i) begin
            pend_d = (lat_i == '0);
            cnt_d  = lat_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o = pend_q | (cnt_q != '0);

    // Ready when idle or when the value is forwardable this cycle.
    assign ready_now_o = ~busy_o
                       | (cnt_q == LAT_W'(1))
                       | (pend_q & wb_hit_i);
endmodule

// File: rtl/hazard_scoreboard.sv
// Register scoreboard between ID and EX: stalls on pending sources,
// passes branch redirect through, counts stall cycles (saturating).
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_REGS   = 32,
    parameter int REG_ADDR_W = 5,
    parameter int LAT_W      = HAZ_LAT_W,
    parameter int CNT_W      = 32
) (
    input logic               clk,
    input logic               reset,
    hazard_scoreboard_if.slave sb
);
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] ready_now;
    logic                rs1_ok, rs2_ok;
    logic                data_stall;
    logic                issue_eff;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    hazard_out_t         hz;

    // Register 0 is hardwired zero and always ready.
    assign busy[0]      = 1'b0;
    assign ready_now[0] = 1'b1;

    assign rs1_ok = ~sb.if_id_rs1_used | ready_now[sb.if_id_rs1];
    assign rs2_ok = ~sb.if_id_rs2_used | ready_now[sb.if_id_rs2];

    // Redirect outranks data stalls; reset suppresses all stalls.
    assign data_stall = ~reset & ~sb.beu_redirect & ~(rs1_ok & rs2_ok);

    assign issue_eff = sb.issue_valid & ~sb.beu_redirect
                     & ~data_stall & (sb.issue_rd != '0);

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_ent
        hazard_sb_entry #(.LAT_W(LAT_W)) u_ent (
            .clk         (clk),
            .reset       (reset),
            .issue_i     (issue_eff && sb.issue_rd == REG_ADDR_W'(r)),
            .lat_i       (sb.issue_lat),
            .wb_hit_i    (sb.wb_valid && sb.wb_rd == REG_ADDR_W'(r)),
            .busy_o      (busy[r]),
            .ready_now_o (ready_now[r])
        );
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (data_stall && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    always_comb begin
        hz                   = '0;
        hz.is_data_stall     = data_stall;
        hz.PCWrite_n         = data_stall;
        hz.if_id_Write_n     = data_stall;
        hz.is_control_hazard = sb.beu_redirect;
    end

    assign sb.PCWrite_n         = hz.PCWrite_n;
    assign sb.if_id_Write_n     = hz.if_id_Write_n;
    assign sb.is_data_stall     = hz.is_data_stall;
    assign sb.is_control_hazard = hz.is_control_hazard;
    assign sb.busy_vec          = busy;
    assign sb.stall_count       = stall_cnt_q;
endmodule
